// File: rtl/ssd_driver_pkg.sv
// Shared types and helpers for the seven-segment driver: FSM encoding,
// segment patterns ({g,f,e,d,c,b,a}, active-low), decoder and BCD add-3 step.
package ssd_driver_pkg;

    localparam int NUM_W   = 13;
    localparam int BCD_W   = 16;
    localparam int SHIFT_W = BCD_W + NUM_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_driver_if.sv
// Display-side bundle: binary value in, multiplexed anode/segment drive out.
interface ssd_driver_if;
    import ssd_driver_pkg::*;

    logic [NUM_W-1:0] num_i;
    logic [3:0]       anode_o;
    logic [6:0]       seg_o;

    modport master (output num_i, input  anode_o, input  seg_o);
    modport slave  (input  num_i, output anode_o, output seg_o);
endinterface

// File: rtl/ssd_driver_bin2bcd.sv
// Iterative binary-to-BCD converter; restarts whenever the input differs from
// the last value it captured.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | holding result, waiting for i_num to differ from r_last_q
// ST_CONV | one add-3 + shift per cycle, 13 cycles, then publish result
module ssd_driver_bin2bcd
    import ssd_driver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] i_num,
    output logic [BCD_W-1:0] o_bcd
);

    conv_state_t          r_state;
    logic [SHIFT_W-1:0]   r_shift;
    logic [3:0]           r_cnt;
    logic [NUM_W-1:0]     r_last_q;
    logic [BCD_W-1:0]     r_bcd_q;

    logic [SHIFT_W-1:0]   w_step;
    logic [SHIFT_W-1:0]   w_next;

    assign w_step = {bcd_add3(r_shift[SHIFT_W-1 -: BCD_W]), r_shift[NUM_W-1:0]};
    assign w_next = {w_step[SHIFT_W-2:0], 1'b0};
    assign o_bcd  = r_bcd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_last_q <= '0;
            r_bcd_q  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_num != r_last_q) begin
                        r_shift  <= {{BCD_W{1'b0}}, i_num};
                        r_last_q <= i_num;
                        r_cnt    <= 4'(NUM_W - 1);
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_shift <= w_next;
                    // Terminal count marks the 13th shift.
                    if (r_cnt == 4'd0) begin
                        r_bcd_q <= w_next[SHIFT_W-1 -: BCD_W];
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed common-anode display driver with registered outputs.
// Optional leading-zero blanking is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module ssd_driver
    import ssd_driver_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic         clk,
    input  logic         rst,
    ssd_driver_if.slave  bus
);

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode;
    logic [6:0]              r_seg;

    logic [BCD_W-1:0]        w_bcd;
    logic [1:0]              w_sel;
    logic [3:0]              w_nib;
    logic                    w_blank;

    ssd_driver_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .i_num (bus.num_i),
        .o_bcd (w_bcd)
    );

    assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_nib = w_bcd[{w_sel, 2'b00} +: 4];

    always_comb begin
        w_blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        case (w_sel)
            2'd1:    w_blank = (w_bcd[15:4]  == 12'd0);
            2'd2:    w_blank = (w_bcd[15:8]  == 8'd0);
            2'd3:    w_blank = (w_bcd[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh <= '0;
            r_anode   <= 4'b1111;
            r_seg     <= SEG_BLANK;
        end else begin
            r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (w_blank) begin
                r_anode <= 4'b1111;
                r_seg   <= SEG_BLANK;
            end else begin
                r_anode <= ~(4'b0001 << w_sel);
                r_seg   <= seg_decode(w_nib);
            end
        end
    end

    assign bus.anode_o = r_anode;
    assign bus.seg_o   = r_seg;

endmodule

// File: tb/tb_ssd_driver.sv
// Directed bench for ssd_driver with a 4-bit refresh counter.
module tb_ssd_driver;
    import ssd_driver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    ssd_driver_if ssd_if ();

    ssd_driver #(.REFRESH_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ssd_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic exp_blank(input logic [15:0] val, input int sel);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        logic [15:0] upper;
        upper = val >> (4 * sel);
        return (sel != 0) && (upper == 16'd0);
`else
        return (val == 16'hFFFF) && (sel < 0);
`endif
    endfunction

    // Output after edge number cyc reflects the refresh count before that edge.
    task automatic check_scan(input string tag, input logic [15:0] val);
        int          sel;
        logic [3:0]  one_hot;
        logic [15:0] tmp;
        logic [3:0]  exp_an;
        logic [6:0]  exp_sg;
        sel     = ((cyc - 1) % 16) / 4;
        one_hot = 4'b0001 << sel;
        tmp     = val >> (4 * sel);
        if (exp_blank(val, sel)) begin
            exp_an = 4'b1111;
            exp_sg = 7'b1111111;
        end else begin
            exp_an = ~one_hot;
            exp_sg = exp_seg(tmp[3:0]);
        end
        check({tag, "_anode"}, 32'(ssd_if.anode_o), 32'(exp_an));
        check({tag, "_seg"},   32'(ssd_if.seg_o),   32'(exp_sg));
    endtask

    initial begin
        ssd_if.num_i = 13'd0;

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1;
        check("rst_anode", 32'(ssd_if.anode_o), 32'h0000000F);
        check("rst_seg",   32'(ssd_if.seg_o),   32'h0000007F);
        check("rst_bcd",   32'(dut.u_bin2bcd.r_bcd_q), 32'h0);
        check("rst_state", 32'(dut.u_bin2bcd.r_state), 32'(ST_IDLE));
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;

        // Zero input: no conversion, full scan of 0000
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("scan0", 16'h0000);
        end
        check("zero_state", 32'(dut.u_bin2bcd.r_state), 32'(ST_IDLE));
        check("zero_bcd",   32'(dut.u_bin2bcd.r_bcd_q), 32'h0);

        // 1234: result lands exactly at E13
        ssd_if.num_i = 13'd1234;
        tick();
        for (int i = 0; i < 12; i++) tick();
        check("b1234_e12", 32'(dut.u_bin2bcd.r_bcd_q), 32'h0);
        tick();
        check("b1234_e13", 32'(dut.u_bin2bcd.r_bcd_q), 32'h1234);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("scan1234", 16'h1234);
        end

        // 8191 with a change to 42 during the 5th conversion cycle
        ssd_if.num_i = 13'd8191;
        tick();
        for (int i = 0; i < 4; i++) tick();
        ssd_if.num_i = 13'd42;
        for (int i = 0; i < 8; i++) tick();
        check("b8191_e12", 32'(dut.u_bin2bcd.r_bcd_q), 32'h1234);
        tick();
        check("b8191_e13", 32'(dut.u_bin2bcd.r_bcd_q), 32'h8191);
        tick();
        check("b42_load",  32'(dut.u_bin2bcd.r_bcd_q), 32'h8191);
        for (int i = 0; i < 12; i++) tick();
        check("b42_e12",   32'(dut.u_bin2bcd.r_bcd_q), 32'h8191);
        tick();
        check("b42_e13",   32'(dut.u_bin2bcd.r_bcd_q), 32'h0042);

        // Reset during the 7th conversion cycle, restart with 5
        ssd_if.num_i = 13'd999;
        tick();
        for (int i = 0; i < 6; i++) tick();
        #2 rst = 1'b0;
        #1;
        check("mid_anode", 32'(ssd_if.anode_o), 32'h0000000F);
        check("mid_seg",   32'(ssd_if.seg_o),   32'h0000007F);
        check("mid_bcd",   32'(dut.u_bin2bcd.r_bcd_q), 32'h0);
        ssd_if.num_i = 13'd5;
        tick();
        rst = 1'b1;
        cyc = 0;
        tick();
        for (int i = 0; i < 12; i++) tick();
        check("b5_e12", 32'(dut.u_bin2bcd.r_bcd_q), 32'h0);
        tick();
        check("b5_e13", 32'(dut.u_bin2bcd.r_bcd_q), 32'h0005);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("scan5", 16'h0005);
        end

        // 7: leading-zero behaviour depends on the build option
        ssd_if.num_i = 13'd7;
        tick();
        for (int i = 0; i < 13; i++) tick();
        check("b7_e13", 32'(dut.u_bin2bcd.r_bcd_q), 32'h0007);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_scan("scan7", 16'h0007);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_driver.md
# ssd_driver

Four-digit seven-segment display driver that sits directly downstream of the CPU's 13-bit `ssd_o` debug output and drives the board's multiplexed common-anode display. The block converts the binary value to four BCD digits with an iterative shift-add-3 (double-dabble) engine, then time-multiplexes the digits with a free-running refresh counter. Conversion re-triggers whenever the input value changes, so the display follows `ssd_sel_i` and the PC live.

## Interface
- `REFRESH_BITS`, default 18: width of the refresh counter; its top two bits select the active digit.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `num_i`  input  13: binary value to display, 0..8191; connects to the CPU's `ssd_o`.
- `anode_o`  output  4: digit enables, active-low; bit 0 is the ones digit.
- `seg_o`  output  7: segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- Reset (async, `rst`=0) values:
  - `anode_o`=4'b1111, `seg_o`=7'b1111111.
  - refresh counter=0, FSM=IDLE, `last_q`=0, `bcd_q`=16'h0000.
- FSM states: IDLE and CONV.
- IDLE:
  - If `num_i` != `last_q`: load shift register {16'b0, `num_i`}, capture `num_i` into `last_q`, clear the shift count, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one step per cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift the 29-bit register left by 1.
  - After the 13th shift, write the upper 16 bits to `bcd_q` and return to IDLE.
- `num_i` changes during CONV are ignored. They are picked up in IDLE on the next cycle because `last_q` differs.
- Max input 8191 yields 16'h8191. The thousands nibble never exceeds 8, so no overflow handling is needed.
- Refresh counter: `REFRESH_BITS` wide, free-running, wraps from all-ones to 0.
- Digit select `sel` = counter[MSB:MSB-1].
  - `anode_o` = ~(4'b0001 << `sel`).
  - `seg_o` = decode(`bcd_q` nibble `sel`).
- Decode 0-9 to the standard patterns, e.g. 0→7'b1000000, 3→7'b0110000, 8→7'b0000000.
- Nibbles 10-15 are unreachable; they decode to blank (7'b1111111).
- `anode_o` and `seg_o` are registered, so they change one cycle after `sel` changes.

## Timing
- Conversion latency:
  - A value change is sampled at load edge E0.
  - Shifts occur at E1..E13.
  - `bcd_q` is updated at E13, 13 cycles after load.
  - The display shows the new value on the first output-register update after E13.
- Back-to-back changes: the next load happens at E14 at the earliest.
- Each digit is active for 2^(`REFRESH_BITS`-2) cycles; the full scan period is 2^`REFRESH_BITS` cycles.
- Reset asserted mid-conversion: state is lost immediately and outputs are blank.
- After reset release with `num_i`=0, no conversion starts and the display shows 0000.
- After reset release with `num_i`!=0, a conversion starts on the first edge.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined:
  - Digit k (k=1..3) is blanked when nibbles k..3 are all zero.
  - Blanked means its `anode_o` bit stays 1 during its slot and `seg_o`=7'b1111111.
  - Digit 0 is always shown.
- `SSD_LEADING_ZERO_BLANK_EN` not defined: all four digits are always displayed, including leading zeros.

## Structure
- Segment encodings for 0-9, the blank pattern, and FSM state encodings go in `defines.v` alongside the existing CPU constants.
- One sub-module: `bin2bcd`, which holds the FSM, shift register, count, `last_q` and `bcd_q`.
- The top level keeps the refresh counter, digit mux, decoder, blanking logic and output registers.

## Test plan
Bench uses `REFRESH_BITS`=4.
- Reset: `rst`=0 asynchronously mid-cycle → `anode_o`=4'b1111 and `seg_o`=7'b1111111 immediately, with no clock edge.
- Release with `num_i`=0 → scan shows digit 0 with 7'b1000000 on each anode 1110, 1101, 1011, 0111 in turn, every 4 cycles.
- `num_i`=1234 → `bcd_q`=16'h1234 exactly 13 cycles after the load edge; the slot with `anode_o`=4'b1101 shows `seg_o`=7'b0110000.
- `num_i`=8191 → `bcd_q`=16'h8191. Then change `num_i` to 42 at the 5th CONV cycle → the first result is 16'h8191, followed by 16'h0042 13 cycles after reload.
- Assert reset at the 7th CONV cycle, release with `num_i`=5 → `bcd_q`=16'h0005 after 13 cycles, with no stale partial value.
- With the macro defined and `num_i`=7 → anodes for digits 1-3 never go low and digit 0 shows 7'b1111000. Without the macro, digits 1-3 show 7'b1000000.
